// File: rtl/line_pp_pkg.sv
// Shared types and widths for the ping-pong line-buffer controller.
package line_pp_pkg;

    localparam int unsigned ADDR_W = 11;
    localparam int unsigned PIX_W  = 8;
    localparam int unsigned CNT_W  = 12;

    typedef enum logic [1:0] {
        W_IDLE,
        W_LINE,
        W_FLUSH,
        W_SWAP
    } wr_state_t;

    typedef enum logic {
        R_IDLE,
        R_RUN
    } rd_state_t;

endpackage

// File: rtl/line_pp_reader.sv
// Readback engine: reads a stored line of len pixels and frames it as a stream.
module line_pp_reader
    import line_pp_pkg::*;
#(
    parameter bit MIRROR = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  len,
    output logic              ram_re,
    output logic [ADDR_W-1:0] ram_raddr,
    input  logic [PIX_W-1:0]  ram_rdata,
    output logic              out_valid,
    output logic [PIX_W-1:0]  out_data,
    output logic              out_first,
    output logic              out_last,
    output logic              overrun
);

    rd_state_t         state, state_nxt;
    logic [CNT_W-1:0]  len_q, len_nxt;
    logic [CNT_W-1:0]  idx, idx_nxt;
    logic              re_nxt;
    logic [ADDR_W-1:0] raddr_nxt;
    logic              first_nxt, last_nxt, overrun_nxt;
    logic              first_rd, last_rd;

    assign first_rd = (idx == '0);
    assign last_rd  = (idx == len_q - CNT_W'(1));

    // Read data is only meaningful alongside out_valid; hold zero otherwise.
    assign out_data = out_valid ? ram_rdata : '0;

    // State, address and framing registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= R_IDLE;
            len_q     <= '0;
            idx       <= '0;
            ram_re    <= 1'b0;
            ram_raddr <= '0;
            out_valid <= 1'b0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_nxt;
            len_q     <= len_nxt;
            idx       <= idx_nxt;
            ram_re    <= re_nxt;
            ram_raddr <= raddr_nxt;
            out_valid <= ram_re;
            out_first <= first_nxt;
            out_last  <= last_nxt;
            overrun   <= overrun_nxt;
        end
    end

    // Next read index/address; a start while running aborts and restarts.
    always_comb begin
        state_nxt   = state;
        len_nxt     = len_q;
        idx_nxt     = idx;
        overrun_nxt = overrun;
        first_nxt   = ram_re & first_rd;
        last_nxt    = ram_re & last_rd & ~start;
        if (start) begin
            if (state == R_RUN) begin
                overrun_nxt = 1'b1;
            end
            state_nxt = R_RUN;
            len_nxt   = len;
            idx_nxt   = '0;
        end else if (state == R_RUN) begin
            if (last_rd) begin
                state_nxt = R_IDLE;
            end else begin
                idx_nxt = idx + CNT_W'(1);
            end
        end
        re_nxt    = (state_nxt == R_RUN);
        raddr_nxt = '0;
        if (re_nxt) begin
            raddr_nxt = MIRROR ? ADDR_W'(len_nxt - CNT_W'(1) - idx_nxt)
                               : ADDR_W'(idx_nxt);
        end
    end

endmodule

// File: rtl/line_pp_ctrl.sv
// Line-buffer controller: writes one line per bank, swaps, reads it back.
module line_pp_ctrl
    import line_pp_pkg::*;
#(
    parameter int unsigned MAX_W  = 2048,
    parameter bit          MIRROR = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pix_de,
    input  logic [PIX_W-1:0]  pix_data,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_waddr,
    output logic [PIX_W-1:0]  ram_wdata,
    output logic              ram_line_end,
    output logic              ram_re,
    output logic [ADDR_W-1:0] ram_raddr,
    input  logic [PIX_W-1:0]  ram_rdata,
    output logic              out_valid,
    output logic [PIX_W-1:0]  out_data,
    output logic              out_first,
    output logic              out_last,
    output logic              overrun
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_W);

    wr_state_t        wr_state, wr_state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             we_c;

    // Write port follows the input pixel directly; forced quiet while in reset.
    assign ram_we    = we_c & rst_n;
    assign ram_waddr = ram_we ? ADDR_W'(cnt) : '0;
    assign ram_wdata = ram_we ? pix_data : '0;

    // Writer state, pixel counter and registered swap pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_state     <= W_IDLE;
            cnt          <= '0;
            ram_line_end <= 1'b0;
        end else begin
            wr_state     <= wr_state_nxt;
            cnt          <= cnt_nxt;
            ram_line_end <= (wr_state_nxt == W_SWAP);
        end
    end

    // The de-low cycle that closes a line doubles as the one-cycle flush slot,
    // so the line end is announced two cycles after the last pixel.
    always_comb begin
        wr_state_nxt = wr_state;
        cnt_nxt      = cnt;
        we_c         = 1'b0;
        case (wr_state)
            W_IDLE, W_LINE: begin
                if (pix_de) begin
                    wr_state_nxt = W_LINE;
                    if (cnt < MAX_CNT) begin
                        we_c    = 1'b1;
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end else if (wr_state == W_LINE) begin
                    wr_state_nxt = W_SWAP;
                end
            end
            W_FLUSH: wr_state_nxt = W_SWAP;
            W_SWAP: begin
                wr_state_nxt = W_IDLE;
                cnt_nxt      = '0;
            end
            default: wr_state_nxt = W_IDLE;
        endcase
    end

    // Reader starts on the swap pulse with the length of the completed line.
    line_pp_reader #(
        .MIRROR (MIRROR)
    ) u_reader (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (ram_line_end),
        .len       (cnt),
        .ram_re    (ram_re),
        .ram_raddr (ram_raddr),
        .ram_rdata (ram_rdata),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_first (out_first),
        .out_last  (out_last),
        .overrun   (overrun)
    );

endmodule

// File: tb/tb_line_pp_ctrl.sv
// Directed bench for line_pp_ctrl: normal and mirrored instances, each with a ping-pong RAM model.
module tb_line_pp_ctrl;

    localparam int unsigned AW = 11;
    localparam int unsigned DW = 8;

    typedef struct {
        int          cyc;
        logic [10:0] a;
        logic [7:0]  d;
    } wrec_t;

    typedef struct {
        int         cyc;
        logic [7:0] d;
        logic       f;
        logic       l;
    } orec_t;

    logic          clk;
    logic          rst_n;
    logic          pix_de;
    logic [DW-1:0] pix_data;

    logic          ram_we0, ram_line_end0, ram_re0, out_valid0, out_first0, out_last0, overrun0;
    logic [AW-1:0] ram_waddr0, ram_raddr0;
    logic [DW-1:0] ram_wdata0, ram_rdata0, out_data0;
    logic          ram_we1, ram_line_end1, ram_re1, out_valid1, out_first1, out_last1, overrun1;
    logic [AW-1:0] ram_waddr1, ram_raddr1;
    logic [DW-1:0] ram_wdata1, ram_rdata1, out_data1;

    logic [44:0] outs0, outs1;
    assign outs0 = {ram_we0, ram_waddr0, ram_wdata0, ram_line_end0, ram_re0, ram_raddr0,
                    out_valid0, out_data0, out_first0, out_last0, overrun0};
    assign outs1 = {ram_we1, ram_waddr1, ram_wdata1, ram_line_end1, ram_re1, ram_raddr1,
                    out_valid1, out_data1, out_first1, out_last1, overrun1};

    int cyc = 0;
    int total = 0;
    int bad = 0;

    wrec_t       wq[$];
    int          leq[$];
    orec_t       oq0[$];
    orec_t       oq1[$];
    logic [10:0] rq0[$];
    logic [10:0] rq1[$];

    line_pp_ctrl #(.MAX_W(2048), .MIRROR(1'b0)) u_dut (
        .clk(clk), .rst_n(rst_n), .pix_de(pix_de), .pix_data(pix_data),
        .ram_we(ram_we0), .ram_waddr(ram_waddr0), .ram_wdata(ram_wdata0),
        .ram_line_end(ram_line_end0), .ram_re(ram_re0), .ram_raddr(ram_raddr0),
        .ram_rdata(ram_rdata0), .out_valid(out_valid0), .out_data(out_data0),
        .out_first(out_first0), .out_last(out_last0), .overrun(overrun0)
    );

    line_pp_ctrl #(.MAX_W(2048), .MIRROR(1'b1)) u_mir (
        .clk(clk), .rst_n(rst_n), .pix_de(pix_de), .pix_data(pix_data),
        .ram_we(ram_we1), .ram_waddr(ram_waddr1), .ram_wdata(ram_wdata1),
        .ram_line_end(ram_line_end1), .ram_re(ram_re1), .ram_raddr(ram_raddr1),
        .ram_rdata(ram_rdata1), .out_valid(out_valid1), .out_data(out_data1),
        .out_first(out_first1), .out_last(out_last1), .overrun(overrun1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Ping-pong RAM models: write bank flips on line_end, read from the other bank, 1-cycle read latency.
    logic [7:0] mem0 [0:1][0:2047];
    logic [7:0] mem1 [0:1][0:2047];
    logic       wb0, wb1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb0 <= 1'b0;
            ram_rdata0 <= '0;
        end else begin
            if (ram_we0) mem0[wb0][ram_waddr0] <= ram_wdata0;
            if (ram_re0) ram_rdata0 <= mem0[~wb0][ram_raddr0];
            if (ram_line_end0) wb0 <= ~wb0;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb1 <= 1'b0;
            ram_rdata1 <= '0;
        end else begin
            if (ram_we1) mem1[wb1][ram_waddr1] <= ram_wdata1;
            if (ram_re1) ram_rdata1 <= mem1[~wb1][ram_raddr1];
            if (ram_line_end1) wb1 <= ~wb1;
        end
    end

    // Record DUT activity mid-cycle for later inspection by the tests.
    always @(negedge clk) begin
        if (rst_n) begin
            if (ram_we0) wq.push_back('{cyc: cyc, a: ram_waddr0, d: ram_wdata0});
            if (ram_line_end0) leq.push_back(cyc);
            if (out_valid0) oq0.push_back('{cyc: cyc, d: out_data0, f: out_first0, l: out_last0});
            if (out_valid1) oq1.push_back('{cyc: cyc, d: out_data1, f: out_first1, l: out_last1});
            if (ram_re0) rq0.push_back(ram_raddr0);
            if (ram_re1) rq1.push_back(ram_raddr1);
        end
    end

    task automatic clear_q();
        wq.delete();
        leq.delete();
        oq0.delete();
        oq1.delete();
        rq0.delete();
        rq1.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic drive_line(input int n, input logic [7:0] base, output int t_last);
        t_last = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            pix_de   = 1'b1;
            pix_data = base + 8'(i);
            t_last   = cyc;
        end
        @(posedge clk);
        #1;
        pix_de   = 1'b0;
        pix_data = '0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #2;
        total++;
        if (outs0 !== 45'd0) begin
            bad++;
            $display("FAIL reset_outs_normal: got %h want 0", outs0);
        end
        total++;
        if (outs1 !== 45'd0) begin
            bad++;
            $display("FAIL reset_outs_mirror: got %h want 0", outs1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        idle(3);
        #2;
        total++;
        if (outs0 !== 45'd0) begin
            bad++;
            $display("FAIL idle_outs_normal: got %h want 0", outs0);
        end
    endtask

    task automatic test_basic();
        int t;
        int e;
        clear_q();
        drive_line(8, 8'h10, t);
        idle(20);
        total++;
        if (wq.size() !== 8) begin
            bad++;
            $display("FAIL basic_wr_count: got %0d want 8", wq.size());
        end else begin
            e = 0;
            for (int i = 0; i < 8; i++)
                if (wq[i].a !== 11'(i) || wq[i].d !== 8'h10 + 8'(i) || wq[i].cyc !== t - 7 + i) e++;
            total++;
            if (e !== 0) begin
                bad++;
                $display("FAIL basic_wr_seq: got %0d bad entries want 0", e);
            end
        end
        total++;
        if (leq.size() !== 1 || leq[0] !== t + 2) begin
            bad++;
            $display("FAIL basic_line_end: got n=%0d cyc=%0d want n=1 cyc=%0d", leq.size(),
                     (leq.size() > 0) ? leq[0] : -1, t + 2);
        end
        total++;
        if (oq0.size() !== 8) begin
            bad++;
            $display("FAIL basic_out_count: got %0d want 8", oq0.size());
        end else begin
            e = 0;
            for (int i = 0; i < 8; i++)
                if (oq0[i].d !== 8'h10 + 8'(i) || oq0[i].f !== (i == 0) || oq0[i].l !== (i == 7)
                    || oq0[i].cyc !== t + 4 + i) e++;
            total++;
            if (e !== 0) begin
                bad++;
                $display("FAIL basic_out_seq: got %0d bad entries want 0", e);
            end
            total++;
            if (oq0[0].cyc !== t + 4) begin
                bad++;
                $display("FAIL basic_first_latency: got cyc %0d want %0d", oq0[0].cyc, t + 4);
            end
        end
        total++;
        if (rq1.size() !== 8 || oq1.size() !== 8) begin
            bad++;
            $display("FAIL mirror_count: got re=%0d out=%0d want 8/8", rq1.size(), oq1.size());
        end else begin
            e = 0;
            for (int i = 0; i < 8; i++)
                if (rq1[i] !== 11'(7 - i) || oq1[i].d !== 8'h17 - 8'(i)
                    || oq1[i].f !== (i == 0) || oq1[i].l !== (i == 7)) e++;
            total++;
            if (e !== 0) begin
                bad++;
                $display("FAIL mirror_seq: got %0d bad entries want 0", e);
            end
        end
    endtask

    task automatic test_oversize();
        int t;
        int e;
        clear_q();
        drive_line(2050, 8'h00, t);
        idle(2060);
        total++;
        if (wq.size() !== 2048) begin
            bad++;
            $display("FAIL ovs_wr_count: got %0d want 2048", wq.size());
        end else begin
            e = 0;
            for (int i = 0; i < 2048; i++)
                if (wq[i].a !== 11'(i) || wq[i].d !== 8'(i)) e++;
            total++;
            if (e !== 0) begin
                bad++;
                $display("FAIL ovs_wr_seq: got %0d bad entries want 0", e);
            end
            total++;
            if (wq[2047].cyc !== t - 2) begin
                bad++;
                $display("FAIL ovs_last_write: got cyc %0d want %0d", wq[2047].cyc, t - 2);
            end
        end
        total++;
        if (oq0.size() !== 2048 || rq0.size() !== 2048) begin
            bad++;
            $display("FAIL ovs_rd_count: got out=%0d re=%0d want 2048", oq0.size(), rq0.size());
        end else begin
            e = 0;
            for (int i = 0; i < 2048; i++)
                if (rq0[i] !== 11'(i) || oq0[i].d !== 8'(i) || oq0[i].l !== (i == 2047)) e++;
            total++;
            if (e !== 0) begin
                bad++;
                $display("FAIL ovs_rd_seq: got %0d bad entries want 0", e);
            end
            total++;
            if (oq0[2047].cyc !== t + 3 + 2048) begin
                bad++;
                $display("FAIL ovs_last_cyc: got %0d want %0d", oq0[2047].cyc, t + 3 + 2048);
            end
        end
        total++;
        if (rq1.size() !== 2048 || oq1.size() !== 2048) begin
            bad++;
            $display("FAIL ovs_mirror_count: got re=%0d out=%0d want 2048", rq1.size(), oq1.size());
        end else begin
            e = 0;
            for (int i = 0; i < 2048; i++)
                if (rq1[i] !== 11'(2047 - i) || oq1[i].d !== 8'(2047 - i)) e++;
            total++;
            if (e !== 0) begin
                bad++;
                $display("FAIL ovs_mirror_seq: got %0d bad entries want 0", e);
            end
        end
    endtask

    task automatic test_single();
        int t;
        clear_q();
        drive_line(1, 8'hA5, t);
        idle(10);
        total++;
        if (wq.size() !== 1 || leq.size() !== 1) begin
            bad++;
            $display("FAIL single_wr: got wr=%0d le=%0d want 1/1", wq.size(), leq.size());
        end else if (wq[0].a !== 11'd0 || leq[0] !== t + 2) begin
            bad++;
            $display("FAIL single_wr: got addr=%0d le_cyc=%0d want 0/%0d", wq[0].a, leq[0], t + 2);
        end
        total++;
        if (oq0.size() !== 1) begin
            bad++;
            $display("FAIL single_out_count: got %0d want 1", oq0.size());
        end else if (oq0[0].f !== 1'b1 || oq0[0].l !== 1'b1 || oq0[0].d !== 8'hA5
                     || oq0[0].cyc !== t + 4) begin
            bad++;
            $display("FAIL single_out: got f=%b l=%b d=%h cyc=%0d want 1 1 a5 %0d",
                     oq0[0].f, oq0[0].l, oq0[0].d, oq0[0].cyc, t + 4);
        end
    endtask

    task automatic test_overrun();
        int ta, tb, tc;
        int e;
        logic       ef, el;
        logic [7:0] ed;
        int         ec;
        clear_q();
        drive_line(100, 8'h00, ta);
        idle(1);
        drive_line(100, 8'h80, tb);
        idle(40);
        #2;
        total++;
        if (overrun0 !== 1'b0) begin
            bad++;
            $display("FAIL ovr_not_yet: got %b want 0", overrun0);
        end
        drive_line(10, 8'h40, tc);
        idle(30);
        total++;
        if (overrun0 !== 1'b1 || overrun1 !== 1'b1) begin
            bad++;
            $display("FAIL ovr_set: got %b/%b want 1/1", overrun0, overrun1);
        end
        total++;
        if (oq0.size() !== 161) begin
            bad++;
            $display("FAIL ovr_out_count: got %0d want 161", oq0.size());
        end else begin
            e = 0;
            for (int i = 0; i < 161; i++) begin
                ef = (i == 0 || i == 100 || i == 151);
                el = (i == 99 || i == 160);
                if (i < 100) begin
                    ed = 8'(i);
                    ec = ta + 4 + i;
                end else if (i < 151) begin
                    ed = 8'h80 + 8'(i - 100);
                    ec = tb + 4 + (i - 100);
                end else begin
                    ed = 8'h40 + 8'(i - 151);
                    ec = tc + 4 + (i - 151);
                end
                if (oq0[i].f !== ef || oq0[i].l !== el || oq0[i].d !== ed || oq0[i].cyc !== ec) e++;
            end
            total++;
            if (e !== 0) begin
                bad++;
                $display("FAIL ovr_stream: got %0d bad entries want 0", e);
            end
            e = 0;
            for (int i = 100; i < 151; i++)
                if (oq0[i].l !== 1'b0) e++;
            total++;
            if (e !== 0) begin
                bad++;
                $display("FAIL ovr_aborted_last: got %0d last flags want 0", e);
            end
            total++;
            if (oq0[151].f !== 1'b1 || oq0[151].d !== 8'h40) begin
                bad++;
                $display("FAIL ovr_restart: got f=%b d=%h want 1 40", oq0[151].f, oq0[151].d);
            end
        end
        total++;
        if (rq1.size() !== 161) begin
            bad++;
            $display("FAIL ovr_mirror_count: got %0d want 161", rq1.size());
        end else if (rq1[150] !== 11'd49 || rq1[151] !== 11'd9 || rq1[160] !== 11'd0) begin
            bad++;
            $display("FAIL ovr_mirror_restart: got %0d %0d %0d want 49 9 0", rq1[150], rq1[151], rq1[160]);
        end
        idle(5);
        #2;
        total++;
        if (overrun0 !== 1'b1) begin
            bad++;
            $display("FAIL ovr_sticky: got %b want 1", overrun0);
        end
    endtask

    task automatic test_mid_reset();
        int t;
        int e;
        clear_q();
        drive_line(20, 8'h60, t);
        idle(5);
        #1;
        rst_n = 1'b0;
        #1;
        total++;
        if (outs0 !== 45'd0) begin
            bad++;
            $display("FAIL midrst_async_normal: got %h want 0", outs0);
        end
        total++;
        if (outs1 !== 45'd0) begin
            bad++;
            $display("FAIL midrst_async_mirror: got %h want 0", outs1);
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_q();
        drive_line(6, 8'hC0, t);
        idle(15);
        total++;
        if (overrun0 !== 1'b0) begin
            bad++;
            $display("FAIL midrst_overrun: got %b want 0", overrun0);
        end
        total++;
        if (oq0.size() !== 6) begin
            bad++;
            $display("FAIL midrst_out_count: got %0d want 6", oq0.size());
        end else begin
            e = 0;
            for (int i = 0; i < 6; i++)
                if (oq0[i].d !== 8'hC0 + 8'(i) || oq0[i].f !== (i == 0) || oq0[i].l !== (i == 5)
                    || oq0[i].cyc !== t + 4 + i) e++;
            total++;
            if (e !== 0) begin
                bad++;
                $display("FAIL midrst_out_seq: got %0d bad entries want 0", e);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst_n    = 1'b0;
        pix_de   = 1'b0;
        pix_data = '0;
        test_reset();
        test_basic();
        test_oversize();
        test_single();
        test_overrun();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/line_pp_ctrl.md
# line_pp_ctrl

Line-buffer controller wrapped around the ping-pong line RAM in the 720P video path. It takes the raw pixel stream and writes one line into the active bank with per-pixel addresses. At line end it issues the bank-swap pulse, then reads the just-completed line back as a framed output stream while the next line is being written. Optionally the line is read in reverse order for horizontal mirroring.

## Interface
- `MAX_W`, 2048: maximum stored pixels per line; must be ≤ 2048 (RAM depth, 11-bit address).
- `MIRROR`, 0: 0 = read back in ascending address order; 1 = descending (horizontal mirror).
- `clk`  in  1  single clock for all logic and the RAM.
- `rst_n`  in  1  asynchronous, active-low reset.
- `pix_de`  in  1  input pixel valid; high for contiguous active-line pixels.
- `pix_data`  in  8  input pixel.
- `ram_we`  out  1  write enable to ping-pong RAM.
- `ram_waddr`  out  11  write address.
- `ram_wdata`  out  8  write data.
- `ram_line_end`  out  1  one-cycle bank-swap pulse.
- `ram_re`  out  1  read enable.
- `ram_raddr`  out  11  read address.
- `ram_rdata`  in  8  read data; valid one cycle after `ram_re`.
- `out_valid`  out  1  readback pixel valid.
- `out_data`  out  8  readback pixel.
- `out_first`  out  1  first pixel of the readback line.
- `out_last`  out  1  last pixel of the readback line.
- `overrun`  out  1  sticky: a swap occurred while readback was still in progress.

## Operation
- **Reset values.** All outputs are 0. Writer state is W_IDLE. Reader state is R_IDLE.
- **Writer FSM: W_IDLE → W_LINE → W_FLUSH → W_SWAP → W_IDLE.**
  - W_IDLE: `pix_de` = 1 enters W_LINE with the pixel counter at 0.
  - W_LINE: each cycle with `pix_de` = 1, drive `ram_we` = 1, `ram_waddr` = count, `ram_wdata` = `pix_data` (all combinational from the inputs), then increment count.
  - W_LINE exit: `pix_de` = 0 moves to W_FLUSH.
  - W_FLUSH: exactly one idle cycle, so the RAM's internally delayed write lands in the old bank.
  - W_SWAP: `ram_line_end` = 1 for one cycle. Latch `len` = count and start the reader. Return to W_IDLE.
- **Width rules.**
  - The count is 12 bits and saturates at `MAX_W`.
  - Pixels with index ≥ `MAX_W` are dropped: `ram_we` = 0 for them.
  - `len` is 1..`MAX_W`. A zero-length line cannot occur, because W_LINE is entered only with `pix_de` = 1.
- **De during flush/swap.** `pix_de` = 1 while in W_FLUSH or W_SWAP is a protocol violation. Those pixels are ignored and the writer next enters W_LINE only from W_IDLE.
- **Reader FSM: R_IDLE → R_RUN → R_IDLE.**
  - R_RUN issues `ram_re` = 1 every cycle for `len` cycles.
  - Address sequence: ascending 0..len-1 for `MIRROR` = 0; descending len-1..0 for `MIRROR` = 1.
  - After the last read it returns to R_IDLE.
- **Output framing.**
  - `out_valid`, `out_first` and `out_last` are `ram_re`, first-read and last-read flags, each registered one cycle.
  - `out_data` = `ram_rdata`.
  - For `len` = 1, `out_first` and `out_last` are asserted together.
- **Overrun.** If W_SWAP occurs while the reader is in R_RUN:
  - set `overrun` (sticky until reset);
  - abort the current readback without asserting `out_last`;
  - restart the reader on the new line from its first address.
- **Mid-operation reset.** All FSMs return to idle and `overrun` clears. The RAM bank flag is reset externally with the same reset.

## Timing
- Last pixel written in cycle T. `pix_de` is low at T+1 (W_FLUSH). `ram_line_end` fires at T+2.
- The first `ram_re` is at T+3 and the first `out_valid` at T+4.
- Readback of a line of length L occupies L consecutive cycles. `out_last` is at T+3+L.
- Writes of the next line may start at T+3 at the earliest and overlap readback freely.
- Minimum horizontal blanking is 2 cycles. A line period of ≥ L+2 cycles avoids overrun.

## Structure
- Shared package `line_pp_pkg` holds:
  - writer state enum (W_IDLE, W_LINE, W_FLUSH, W_SWAP);
  - reader state enum (R_IDLE, R_RUN);
  - `ADDR_W` = 11 and `PIX_W` = 8.
- One natural sub-module, `line_pp_reader`: reader FSM, address generator (including `MIRROR`) and output framing registers. It is started by a `start` pulse plus `len`.
- The writer FSM stays in the top level.

## Test plan
- **Basic line.** Line of 8 pixels with data 0x10..0x17 and `MIRROR` = 0 → `ram_waddr` 0..7, `ram_line_end` 2 cycles after the last pixel. `out_data` 0x10..0x17; `out_first` on 0x10, `out_last` on 0x17, first `out_valid` 4 cycles after the last write.
- **Mirror.** Same line with `MIRROR` = 1 → `ram_raddr` 7..0, `out_data` 0x17..0x10.
- **Oversize line.** 2050-pixel line with `MAX_W` = 2048 → last write at addr 2047, no writes for pixels 2048–2049. Readback length 2048, no address wrap.
- **Single pixel.** 1-pixel line → one `out_valid` cycle with `out_first` = `out_last` = 1.
- **Overrun.** 100-pixel lines with 2-cycle blanking, then a 10-pixel line ending while readback is at pixel 50 → `overrun` = 1 and stays 1. Readback restarts at the new line's addr 0 with `out_first`; the aborted line shows no `out_last`.
- **Mid-readback reset.** Assert `rst_n` low during readback → all outputs 0 within the same cycle (asynchronous). A clean line after release reads back correctly.
